// File: rtl/arm_pkg.sv
// Shared decode/execute definitions: ALU command encodings and the packed control bundle.
package arm_pkg;

    localparam int unsigned CTRL_W = 11;

    localparam logic [3:0] EXEC_NOP = 4'b0000;
    localparam logic [3:0] EXEC_MOV = 4'b0001;
    localparam logic [3:0] EXEC_MVN = 4'b1001;
    localparam logic [3:0] EXEC_ADD = 4'b0010;
    localparam logic [3:0] EXEC_ADC = 4'b0011;
    localparam logic [3:0] EXEC_SUB = 4'b0100;
    localparam logic [3:0] EXEC_SBC = 4'b0101;
    localparam logic [3:0] EXEC_AND = 4'b0110;
    localparam logic [3:0] EXEC_ORR = 4'b0111;
    localparam logic [3:0] EXEC_EOR = 4'b1000;
    localparam logic [3:0] EXEC_CMP = EXEC_SUB;
    localparam logic [3:0] EXEC_TST = EXEC_AND;

    typedef struct packed {
        logic [3:0] exec_cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       branch;
        logic       s;
        logic       push_en;
        logic       pop_en;
    } ctrl_t;

    localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; priority is rst > hold > en.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!hold && en && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with freeze, bubble, flush and condition-fail annulment.
// Optional performance counters are built when ID_EX_PERF_EN is defined.
module id_ex_stage_reg
    import arm_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              bubble,
    input  logic              flush,
    input  logic              cond_pass,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [3:0]        exec_cmd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              branch_in,
    input  logic              s_in,
    input  logic              push_en_in,
    input  logic              pop_en_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       simm24_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    output logic [DATA_W-1:0] pc_out,
    output logic [3:0]        exec_cmd_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_en_out,
    output logic              branch_out,
    output logic              s_out,
    output logic              push_en_out,
    output logic              pop_en_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       simm24_out,
    output logic [REG_AW-1:0] dest_out,
    output logic [REG_AW-1:0] src1_out,
    output logic [REG_AW-1:0] src2_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  perf_bubble_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
);

    ctrl_t             ctrl_in, ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d, val_rn_q, val_rn_d, val_rm_q, val_rm_d;
    logic              imm_q, imm_d;
    logic [11:0]       shift_q, shift_d;
    logic [23:0]       simm24_q, simm24_d;
    logic [REG_AW-1:0] dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
    logic              annul;

    assign ctrl_in = '{exec_cmd: exec_cmd_in, mem_read: mem_read_in, mem_write: mem_write_in,
                       wb_en: wb_en_in, branch: branch_in, s: s_in, push_en: push_en_in,
                       pop_en: pop_en_in};

    // A bubble or a failed condition both leave a dead slot behind.
    assign annul = !flush && !freeze && (bubble || !cond_pass);

    always_comb begin
        ctrl_d   = ctrl_q;
        valid_d  = valid_q;
        pc_d     = pc_q;
        val_rn_d = val_rn_q;
        val_rm_d = val_rm_q;
        imm_d    = imm_q;
        shift_d  = shift_q;
        simm24_d = simm24_q;
        dest_d   = dest_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        if (flush) begin
            ctrl_d   = NOP_CTRL;
            valid_d  = 1'b0;
            pc_d     = '0;
            val_rn_d = '0;
            val_rm_d = '0;
            imm_d    = 1'b0;
            shift_d  = '0;
            simm24_d = '0;
            dest_d   = '0;
            src1_d   = '0;
            src2_d   = '0;
        end else if (!freeze) begin
            pc_d     = pc_in;
            val_rn_d = val_rn_in;
            val_rm_d = val_rm_in;
            imm_d    = imm_in;
            shift_d  = shift_operand_in;
            simm24_d = simm24_in;
            if (bubble) begin
                // Zeroed indices keep the forwarding unit from matching a dead slot.
                ctrl_d  = NOP_CTRL;
                valid_d = 1'b0;
                dest_d  = '0;
                src1_d  = '0;
                src2_d  = '0;
            end else begin
                dest_d  = dest_in;
                src1_d  = src1_in;
                src2_d  = src2_in;
                ctrl_d  = cond_pass ? ctrl_in : NOP_CTRL;
                valid_d = cond_pass;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= NOP_CTRL;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            val_rn_q <= '0;
            val_rm_q <= '0;
            imm_q    <= 1'b0;
            shift_q  <= '0;
            simm24_q <= '0;
            dest_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            val_rn_q <= val_rn_d;
            val_rm_q <= val_rm_d;
            imm_q    <= imm_d;
            shift_q  <= shift_d;
            simm24_q <= simm24_d;
            dest_q   <= dest_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
        end
    end

    assign exec_cmd_out      = ctrl_q.exec_cmd;
    assign mem_read_out      = ctrl_q.mem_read;
    assign mem_write_out     = ctrl_q.mem_write;
    assign wb_en_out         = ctrl_q.wb_en;
    assign branch_out        = ctrl_q.branch;
    assign s_out             = ctrl_q.s;
    assign push_en_out       = ctrl_q.push_en;
    assign pop_en_out        = ctrl_q.pop_en;
    assign valid_out         = valid_q;
    assign pc_out            = pc_q;
    assign val_rn_out        = val_rn_q;
    assign val_rm_out        = val_rm_q;
    assign imm_out           = imm_q;
    assign shift_operand_out = shift_q;
    assign simm24_out        = simm24_q;
    assign dest_out          = dest_q;
    assign src1_out          = src1_q;
    assign src2_out          = src2_q;

`ifdef ID_EX_PERF_EN
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (annul),
        .hold  (freeze),
        .count (perf_bubble_cnt)
    );

    // Flush outranks freeze, so a frozen flush still counts.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (flush),
        .hold  (1'b0),
        .count (perf_flush_cnt)
    );
`else
    logic unused_annul;
    assign unused_annul    = annul;
    assign perf_bubble_cnt = '0;
    assign perf_flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg; expected counters depend on ID_EX_PERF_EN.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst, freeze, bubble, flush, cond_pass;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [3:0]  exec_cmd_in;
    logic        mem_read_in, mem_write_in, wb_en_in, branch_in, s_in, push_en_in, pop_en_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] simm24_in;
    logic [3:0]  dest_in, src1_in, src2_in;

    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [3:0]  exec_cmd_out;
    logic        mem_read_out, mem_write_out, wb_en_out, branch_out, s_out, push_en_out;
    logic        pop_en_out, imm_out, valid_out;
    logic [11:0] shift_operand_out;
    logic [23:0] simm24_out;
    logic [3:0]  dest_out, src1_out, src2_out;
    logic [15:0] perf_bubble_cnt, perf_flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk (clk), .rst (rst), .freeze (freeze), .bubble (bubble), .flush (flush),
        .cond_pass (cond_pass), .pc_in (pc_in), .exec_cmd_in (exec_cmd_in),
        .mem_read_in (mem_read_in), .mem_write_in (mem_write_in), .wb_en_in (wb_en_in),
        .branch_in (branch_in), .s_in (s_in), .push_en_in (push_en_in),
        .pop_en_in (pop_en_in), .val_rn_in (val_rn_in), .val_rm_in (val_rm_in),
        .imm_in (imm_in), .shift_operand_in (shift_operand_in), .simm24_in (simm24_in),
        .dest_in (dest_in), .src1_in (src1_in), .src2_in (src2_in),
        .pc_out (pc_out), .exec_cmd_out (exec_cmd_out), .mem_read_out (mem_read_out),
        .mem_write_out (mem_write_out), .wb_en_out (wb_en_out), .branch_out (branch_out),
        .s_out (s_out), .push_en_out (push_en_out), .pop_en_out (pop_en_out),
        .val_rn_out (val_rn_out), .val_rm_out (val_rm_out), .imm_out (imm_out),
        .shift_operand_out (shift_operand_out), .simm24_out (simm24_out),
        .dest_out (dest_out), .src1_out (src1_out), .src2_out (src2_out),
        .valid_out (valid_out), .perf_bubble_cnt (perf_bubble_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    typedef struct packed {
        logic [10:0] ctrl;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [3:0]  dest;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic [15:0] pb;
        logic [15:0] pf;
    } exp_t;

    exp_t   model = '0;
    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic exp_t model_next(input exp_t cur);
        exp_t n = cur;
        if (rst) begin
            n = '0;
        end else if (flush) begin
            n    = '0;
            n.pb = cur.pb;
            n.pf = sat_inc(cur.pf);
        end else if (!freeze) begin
            n.pc   = pc_in;
            n.rn   = val_rn_in;
            n.rm   = val_rm_in;
            n.imm  = imm_in;
            n.sh   = shift_operand_in;
            n.simm = simm24_in;
            if (bubble || !cond_pass) begin
                n.ctrl  = '0;
                n.valid = 1'b0;
                n.pb    = sat_inc(cur.pb);
            end else begin
                n.ctrl  = {exec_cmd_in, mem_read_in, mem_write_in, wb_en_in, branch_in, s_in,
                           push_en_in, pop_en_in};
                n.valid = 1'b1;
            end
            n.dest = bubble ? 4'd0 : dest_in;
            n.s1   = bubble ? 4'd0 : src1_in;
            n.s2   = bubble ? 4'd0 : src2_in;
        end
        return n;
    endfunction

    // Advance one clock; when chk is set the predicted state goes through the scoreboard.
    task automatic step(input bit chk);
        exp_t e;
        model = model_next(model);
        if (chk) sb_q.push_back(model);
        @(posedge clk);
        #1;
        if (chk) begin
            e = sb_q.pop_front();
            check_eq("ctrl", 64'({exec_cmd_out, mem_read_out, mem_write_out, wb_en_out,
                                  branch_out, s_out, push_en_out, pop_en_out}), 64'(e.ctrl));
            check_eq("valid", 64'(valid_out), 64'(e.valid));
            check_eq("pc", 64'(pc_out), 64'(e.pc));
            check_eq("val_rn", 64'(val_rn_out), 64'(e.rn));
            check_eq("val_rm", 64'(val_rm_out), 64'(e.rm));
            check_eq("imm", 64'(imm_out), 64'(e.imm));
            check_eq("shift", 64'(shift_operand_out), 64'(e.sh));
            check_eq("simm24", 64'(simm24_out), 64'(e.simm));
            check_eq("idx", 64'({dest_out, src1_out, src2_out}), 64'({e.dest, e.s1, e.s2}));
`ifdef ID_EX_PERF_EN
            check_eq("perf_bubble", 64'(perf_bubble_cnt), 64'(e.pb));
            check_eq("perf_flush", 64'(perf_flush_cnt), 64'(e.pf));
`else
            check_eq("perf_bubble", 64'(perf_bubble_cnt), 64'd0);
            check_eq("perf_flush", 64'(perf_flush_cnt), 64'd0);
`endif
            if (!valid_out) check_eq("branch_dead", 64'(branch_out), 64'd0);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; freeze = 0; bubble = 0; flush = 0; cond_pass = 1;
        pc_in = '0; val_rn_in = '0; val_rm_in = '0; exec_cmd_in = '0;
        mem_read_in = 0; mem_write_in = 0; wb_en_in = 0; branch_in = 0; s_in = 0;
        push_en_in = 0; pop_en_in = 0; imm_in = 0; shift_operand_in = '0; simm24_in = '0;
        dest_in = '0; src1_in = '0; src2_in = '0;
    endtask

    task automatic rand_payload();
        pc_in = $urandom; val_rn_in = $urandom; val_rm_in = $urandom;
        exec_cmd_in = 4'($urandom); imm_in = 1'($urandom);
        {mem_read_in, mem_write_in, wb_en_in, branch_in, s_in, push_en_in, pop_en_in} =
            7'($urandom);
        shift_operand_in = 12'($urandom); simm24_in = 24'($urandom);
        dest_in = 4'($urandom); src1_in = 4'($urandom); src2_in = 4'($urandom);
    endtask

    initial begin
        idle_inputs();
        // Reset, with garbage on the inputs.
        rst = 1; rand_payload();
        step(1); step(1);
        idle_inputs();

        // Plain ADD load.
        pc_in = 32'h10; exec_cmd_in = 4'b0010; wb_en_in = 1; val_rn_in = 32'h5;
        dest_in = 4'd2; src1_in = 4'd1;
        step(1);

        // Freeze for three cycles while MOV waits on the inputs.
        freeze = 1; pc_in = 32'h20; exec_cmd_in = 4'b0001; dest_in = 4'd7;
        step(1); step(1); step(1);
        freeze = 0;
        step(1);

        // Hazard bubble.
        bubble = 1; mem_read_in = 1; src1_in = 4'd3; pc_in = 32'h24;
        step(1);
        bubble = 0; mem_read_in = 0;

        // Flush together with freeze, then again (idempotent).
        flush = 1; freeze = 1; branch_in = 1; pc_in = 32'h28;
        step(1); step(1);
        flush = 0; freeze = 0; branch_in = 0;

        // Condition-failed store.
        cond_pass = 0; mem_write_in = 1; val_rm_in = 32'hDEAD; exec_cmd_in = 4'b0010;
        step(1);
        cond_pass = 1; mem_write_in = 0;

        // Mixed random traffic across all controls.
        for (int i = 0; i < 40; i++) begin
            rand_payload();
            freeze    = ($urandom_range(0, 3) == 0);
            bubble    = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 5) == 0);
            cond_pass = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 19) == 0);
            step(1);
        end

        // Reset during a stall with a flush pending.
        rand_payload(); freeze = 1; flush = 1; rst = 1;
        step(1);
        idle_inputs();

        // Drive the bubble counter into saturation.
        bubble = 1;
        for (int i = 0; i < 65537; i++) step(0);
        step(1); step(1);
        bubble = 0; cond_pass = 0;
        step(1);
        cond_pass = 1; flush = 1;
        step(1);
        flush = 0;
        step(1);

        if (sb_q.size() != 0) check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
